alu_scoreboard: RTL and testbench

- Parametrised RAW-hazard scoreboard for the ALU issue stage of the shader core.
- Tracks destination registers of in-flight ALU ops through a configurable-depth tracking pipe and gates issue with a valid/ready handshake.
- Optionally reports forwarding selects instead of stalling.
- Sits between decode/issue and the ALU pipeline; one instance per ALU.

---
 rtl/alu_sb_pkg.sv | 17 +
 rtl/alu_sb_match.sv | 33 +++
 rtl/alu_scoreboard.sv | 87 ++++++++
 tb/tb_alu_scoreboard.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sb_pkg.sv
// Shared types and helpers for the ALU issue-stage RAW scoreboard.
package alu_sb_pkg;

  // Widest register address the tracking entry can hold; REG_AW must not exceed it.
  localparam int SB_AW_MAX   = 16;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic                 valid;
    logic [SB_AW_MAX-1:0] dst;
  } sb_entry_t;

  function automatic int fwd_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/alu_sb_match.sv
// Compares one source operand against every tracking stage; reports the
// per-stage match vector and the youngest bypassable stage (k >= 1) as k+1.
module alu_sb_match
  import alu_sb_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int FWD_W  = 2
) (
  input  logic [SB_AW_MAX-1:0]   src_addr,
  input  logic                   src_used,
  input  sb_entry_t [STAGES-1:0] pipe,
  output logic [STAGES-1:0]      match,
  output logic [FWD_W-1:0]       fwd_sel
);

  // NOTE: every variable written in a combinational block gets a default first,
  // so no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    match = '0;
    for (int k = 0; k < STAGES; k++) begin
      match[k] = src_used && pipe[k].valid && (pipe[k].dst == src_addr);
    end
  end

  // Walk oldest to youngest so the lowest matching stage is the one left standing.
  always_comb begin
    fwd_sel = FWD_W'(FWD_REGFILE);
    for (int k = STAGES - 1; k >= 1; k--) begin
      if (match[k]) fwd_sel = FWD_W'(k + 1);
    end
  end

endmodule

// File: rtl/alu_scoreboard.sv
// RAW-hazard scoreboard for the ALU issue stage. Define ALU_SB_FWD_EN to bypass
// from stage 1 upward (fwd_sel_o) instead of stalling on every in-flight match.
module alu_scoreboard
  import alu_sb_pkg::*;
#(
  parameter int REG_AW  = 6,
  parameter int STAGES  = 2,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16,
  localparam int FWD_W  = fwd_width(STAGES)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      issue_valid_i,
  output logic                      issue_ready_o,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr_i,
  input  logic [NUM_SRC-1:0]        src_used_i,
  input  logic [REG_AW-1:0]         dst_addr_i,
  input  logic                      dst_we_i,
  input  logic                      flush_i,
  output logic [NUM_SRC-1:0]        hazard_mask_o,
  output logic                      hazard_o,
  output logic                      busy_o,
  output logic [CNT_W-1:0]          stall_cnt_o
`ifdef ALU_SB_FWD_EN
  ,
  output logic [NUM_SRC*FWD_W-1:0]  fwd_sel_o
`endif
);

  sb_entry_t [STAGES-1:0]          pipe_q;
  logic [NUM_SRC-1:0][STAGES-1:0]  match;
  logic [NUM_SRC*FWD_W-1:0]        fwd_sel;
  logic                            fire;
  logic                            stall;

  for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
    alu_sb_match #(
      .STAGES (STAGES),
      .FWD_W  (FWD_W)
    ) u_match (
      .src_addr (SB_AW_MAX'(src_addr_i[j*REG_AW +: REG_AW])),
      .src_used (src_used_i[j]),
      .pipe     (pipe_q),
      .match    (match[j]),
      .fwd_sel  (fwd_sel[j*FWD_W +: FWD_W])
    );

`ifdef ALU_SB_FWD_EN
    // Stage 0 is still executing, so only it forces a stall.
    assign hazard_mask_o[j] = match[j][0];
`else
    assign hazard_mask_o[j] = |match[j];
`endif
  end

`ifdef ALU_SB_FWD_EN
  assign fwd_sel_o = fwd_sel;
`endif

  assign hazard_o      = |hazard_mask_o;
  assign issue_ready_o = rst_ni && !flush_i && !hazard_o;
  assign fire          = issue_valid_i && issue_ready_o;
  assign stall         = issue_valid_i && !issue_ready_o;

  always_comb begin
    busy_o = 1'b0;
    for (int k = 0; k < STAGES; k++) busy_o = busy_o | pipe_q[k].valid;
  end

  // NOTE: state is updated with non-blocking assignments so each stage reads its
  // neighbour's pre-edge value; the tracking array is small flops, so the dst
  // fields are reset along with the valids rather than left as uninitialised storage.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pipe_q      <= '0;
      stall_cnt_o <= '0;
    end else begin
      pipe_q[0] <= '{valid: fire && dst_we_i, dst: SB_AW_MAX'(dst_addr_i)};
      for (int k = 1; k < STAGES; k++) begin
        pipe_q[k] <= '{valid: pipe_q[k-1].valid && !flush_i, dst: pipe_q[k-1].dst};
      end
      if (stall && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_scoreboard.sv
// Self-checking bench for alu_scoreboard: a behavioural model predicts each
// cycle's outputs into a scoreboard queue; a second instance has CNT_W=4.
module tb_alu_scoreboard;

`ifdef ALU_SB_FWD_EN
  localparam int TB_STAGES = 3;
`else
  localparam int TB_STAGES = 2;
`endif
  localparam int FWD_W = $clog2(TB_STAGES + 1);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [11:0] src_addr = '0;
  logic [1:0]  src_used = '0;
  logic [5:0]  dst_addr = '0;
  logic        dst_we = 1'b0;
  logic        flush = 1'b0;

  logic        ready, hazard, busy;
  logic [1:0]  mask;
  logic [15:0] cnt;
  logic        ready_s, hazard_s, busy_s;
  logic [1:0]  mask_s;
  logic [3:0]  cnt_s;
`ifdef ALU_SB_FWD_EN
  logic [2*FWD_W-1:0] fwd, fwd_s;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_scoreboard #(.REG_AW(6), .STAGES(TB_STAGES), .NUM_SRC(2), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .issue_valid_i(issue_valid), .issue_ready_o(ready),
    .src_addr_i(src_addr), .src_used_i(src_used), .dst_addr_i(dst_addr), .dst_we_i(dst_we),
    .flush_i(flush), .hazard_mask_o(mask), .hazard_o(hazard), .busy_o(busy),
    .stall_cnt_o(cnt)
`ifdef ALU_SB_FWD_EN
    , .fwd_sel_o(fwd)
`endif
  );

  alu_scoreboard #(.REG_AW(6), .STAGES(TB_STAGES), .NUM_SRC(2), .CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .issue_valid_i(issue_valid), .issue_ready_o(ready_s),
    .src_addr_i(src_addr), .src_used_i(src_used), .dst_addr_i(dst_addr), .dst_we_i(dst_we),
    .flush_i(flush), .hazard_mask_o(mask_s), .hazard_o(hazard_s), .busy_o(busy_s),
    .stall_cnt_o(cnt_s)
`ifdef ALU_SB_FWD_EN
    , .fwd_sel_o(fwd_s)
`endif
  );

  typedef struct {
    logic [1:0]         mask;
    logic               ready;
    logic               busy;
    logic [15:0]        cnt;
    logic [2*FWD_W-1:0] fwd;
  } exp_t;

  exp_t        sb_q[$];
  bit          mv[TB_STAGES];
  logic [5:0]  md[TB_STAGES];
  int          cnt_m = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus: predict, drive, sample at the falling edge, advance model.
  task automatic cyc(input bit rst, input bit v, input logic [5:0] s0, input logic [5:0] s1,
                     input logic [1:0] used, input logic [5:0] d, input bit we, input bit fl);
    exp_t       e, g;
    logic [5:0] s[2];
    int         sat;
    @(posedge clk);
    #1;
    rst_n = rst; issue_valid = v; src_addr = {s1, s0}; src_used = used;
    dst_addr = d; dst_we = we; flush = fl;
    s[0] = s0; s[1] = s1;
    e.mask = '0; e.fwd = '0; e.busy = 1'b0; e.cnt = 16'(cnt_m);
    for (int k = 0; k < TB_STAGES; k++) e.busy = e.busy | mv[k];
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < TB_STAGES; k++) begin
        if (used[j] && mv[k] && md[k] == s[j]) begin
`ifdef ALU_SB_FWD_EN
          if (k == 0) e.mask[j] = 1'b1;
          else if (e.fwd[j*FWD_W +: FWD_W] == '0) e.fwd[j*FWD_W +: FWD_W] = FWD_W'(k + 1);
`else
          e.mask[j] = 1'b1;
`endif
        end
      end
    end
    e.ready = rst && !fl && (e.mask == 2'b00);
    sb_q.push_back(e);

    @(negedge clk);
    g = sb_q.pop_front();
    sat = (int'(g.cnt) > 15) ? 15 : int'(g.cnt);
    check("ready", 32'(ready), 32'(g.ready));
    check("mask", 32'(mask), 32'(g.mask));
    check("hazard", 32'(hazard), 32'(g.mask != 2'b00));
    check("busy", 32'(busy), 32'(g.busy));
    check("stall_cnt", 32'(cnt), 32'(g.cnt));
    check("sat_cnt", 32'(cnt_s), 32'(sat));
    check("sat_ready", 32'(ready_s), 32'(g.ready));
`ifdef ALU_SB_FWD_EN
    check("fwd_sel", 32'(fwd), 32'(g.fwd));
`endif

    if (!rst) begin
      for (int k = 0; k < TB_STAGES; k++) begin mv[k] = 1'b0; md[k] = '0; end
      cnt_m = 0;
    end else begin
      if (v && !g.ready && cnt_m < 65535) cnt_m++;
      for (int k = TB_STAGES - 1; k > 0; k--) begin
        mv[k] = mv[k-1] && !fl;
        md[k] = md[k-1];
      end
      mv[0] = v && g.ready && we;
      md[0] = d;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 6'd0, 6'd0, 2'b00, 6'd0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < TB_STAGES; k++) begin mv[k] = 1'b0; md[k] = '0; end

    // Reset state
    cyc(0, 1, 6'd0, 6'd0, 2'b00, 6'd0, 0, 0);
    check("rst_ready_low", 32'(ready), 32'd0);
    cyc(0, 0, 6'd0, 6'd0, 2'b00, 6'd0, 0, 0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);

    // RAW stall on dst=5
    cyc(1, 1, 6'd0, 6'd0, 2'b00, 6'd5, 1, 0);
    cyc(1, 1, 6'd5, 6'd0, 2'b01, 6'd8, 1, 0);
    check("raw_hazard_c1", 32'(hazard), 32'd1);
    cyc(1, 1, 6'd5, 6'd0, 2'b01, 6'd8, 1, 0);
    cyc(1, 1, 6'd5, 6'd0, 2'b01, 6'd8, 1, 0);
`ifndef ALU_SB_FWD_EN
    check("raw_ready_c3", 32'(ready), 32'd1);
    check("raw_stall_cnt", 32'(cnt), 32'd2);
`endif
    idle(4);

    // No write, unused operand, same-instruction src==dst
    cyc(1, 1, 6'd0, 6'd0, 2'b00, 6'd5, 0, 0);
    cyc(1, 1, 6'd5, 6'd5, 2'b01, 6'd1, 0, 0);
    check("no_we_hazard", 32'(hazard), 32'd0);
    idle(3);
    cyc(1, 1, 6'd0, 6'd0, 2'b00, 6'd5, 1, 0);
    cyc(1, 1, 6'd0, 6'd5, 2'b01, 6'd2, 0, 0);
    check("unused_src_hazard", 32'(hazard), 32'd0);
    idle(3);
    cyc(1, 1, 6'd10, 6'd0, 2'b01, 6'd10, 1, 0);
    check("self_dep_hazard", 32'(hazard), 32'd0);
    idle(3);

    // Flush kills tracking
    cyc(1, 1, 6'd0, 6'd0, 2'b00, 6'd7, 1, 0);
    cyc(1, 1, 6'd7, 6'd0, 2'b01, 6'd3, 1, 1);
    check("flush_ready", 32'(ready), 32'd0);
    cyc(1, 1, 6'd7, 6'd0, 2'b01, 6'd3, 0, 0);
    check("post_flush_hazard", 32'(hazard), 32'd0);
    check("post_flush_busy", 32'(busy), 32'd0);
    idle(3);

    // Forwarding patterns: bubble gap, back-to-back, two in flight
    cyc(1, 1, 6'd0, 6'd0, 2'b00, 6'd9, 1, 0);
    idle(1);
    cyc(1, 1, 6'd9, 6'd0, 2'b01, 6'd4, 0, 0);
`ifdef ALU_SB_FWD_EN
    check("fwd_gap_sel", 32'(fwd[FWD_W-1:0]), 32'd2);
    check("fwd_gap_hazard", 32'(hazard), 32'd0);
`endif
    idle(4);
    cyc(1, 1, 6'd0, 6'd0, 2'b00, 6'd9, 1, 0);
    cyc(1, 1, 6'd9, 6'd0, 2'b01, 6'd4, 0, 0);
    check("b2b_hazard", 32'(hazard), 32'd1);
    idle(4);
    cyc(1, 1, 6'd0, 6'd0, 2'b00, 6'd9, 1, 0);
    cyc(1, 1, 6'd0, 6'd0, 2'b00, 6'd9, 1, 0);
    idle(1);
    cyc(1, 1, 6'd0, 6'd9, 2'b10, 6'd4, 0, 0);
`ifdef ALU_SB_FWD_EN
    check("fwd_youngest", 32'(fwd[FWD_W +: FWD_W]), 32'd2);
`endif
    idle(4);

    // Randomised traffic with small register space to force collisions
    for (int i = 0; i < 200; i++) begin
      cyc(($urandom % 50) != 0, 1'($urandom % 2), 6'($urandom % 4), 6'($urandom % 4),
          2'($urandom % 4), 6'($urandom % 4), 1'($urandom % 2), ($urandom % 16) == 0);
    end
    idle(4);

    // Saturation: hold a stall (valid under flush) for 20 cycles
    for (int i = 0; i < 20; i++) cyc(1, 1, 6'd0, 6'd0, 2'b00, 6'd1, 1, 1);
    check("sat_cnt_15", 32'(cnt_s), 32'd15);
    idle(2);

    // Reset with two valid stages
    cyc(1, 1, 6'd0, 6'd0, 2'b00, 6'd1, 1, 0);
    cyc(1, 1, 6'd0, 6'd0, 2'b00, 6'd2, 1, 0);
    cyc(0, 1, 6'd1, 6'd0, 2'b01, 6'd3, 1, 0);
    check("rst_mid_ready", 32'(ready), 32'd0);
    cyc(1, 1, 6'd1, 6'd2, 2'b11, 6'd3, 1, 0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_cnt", 32'(cnt), 32'd0);
    check("rst_mid_hazard", 32'(hazard), 32'd0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
